// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets and the
// "no interrupt" claim value.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    PENDING = 2'd0,
    ENABLE  = 2'd1,
    TRIGGER = 2'd2,
    CLAIM   = 2'd3
  } irq_reg_e;

  localparam int NO_IRQ = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into the clk
// domain; clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments so q takes the old meta value, giving two real stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises irq lines, latches edges or
// follows levels, and raises hwint for the CU with a claim/complete handshake.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               en,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               hwint
);

  logic [NUM_IRQ-1:0] s2;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] trigger;
  logic [NUM_IRQ-1:0] in_service;

  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] claim_mask;
  logic [NUM_IRQ-1:0] cpl_mask;
  logic [NUM_IRQ-1:0] pending_next;
  logic [5:0]         claim_id;
  logic               claim_take;
  logic               bus_rd;
  logic               bus_wr;
  irq_reg_e           reg_sel;
  logic               unused_bits;

  // Lowest index wins; returns id+1, or NO_IRQ when nothing is set.
  function automatic logic [5:0] first_id(input logic [NUM_IRQ-1:0] v);
    first_id = 6'(NO_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) first_id = 6'(i + 1);
    end
  endfunction

  sync_2ff #(.WIDTH(NUM_IRQ)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq),
    .q   (s2)
  );

  assign bus_rd      = en & rd;
  assign bus_wr      = en & wr;
  assign reg_sel     = irq_reg_e'(addr);
  assign unused_bits = ^data_in;

  // Nothing is offered for claim while a handler is running (no nesting).
  assign claim_id   = (in_service == '0) ? first_id(pending & enable) : 6'(NO_IRQ);
  assign claim_take = bus_rd & ~wr & (reg_sel == CLAIM) & (claim_id != 6'(NO_IRQ));

  assign edge_set = s2 & ~prev;
  assign w1c_mask = (bus_wr && reg_sel == PENDING) ? data_in[NUM_IRQ-1:0] : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    claim_mask = '0;
    cpl_mask   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_mask[i] = claim_take && (claim_id == 6'(i + 1));
      cpl_mask[i]   = bus_wr && (reg_sel == CLAIM) && (6'(data_in[4:0]) == 6'(i + 1));
    end
  end

  // Edge sources: clears lose to a same-cycle new edge. Level sources mirror s2.
  assign pending_next = (trigger & ((pending & ~(w1c_mask | claim_mask)) | edge_set))
                      | (~trigger & s2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      pending    <= '0;
      enable     <= '0;
      trigger    <= '0;
      in_service <= '0;
      hwint      <= 1'b0;
    end else begin
      prev       <= s2;
      pending    <= pending_next;
      in_service <= (in_service & ~cpl_mask) | claim_mask;
      hwint      <= (in_service == '0) && |(pending & enable);
      if (bus_wr && reg_sel == ENABLE)  enable  <= data_in[NUM_IRQ-1:0];
      if (bus_wr && reg_sel == TRIGGER) trigger <= data_in[NUM_IRQ-1:0];
    end
  end

  always_comb begin
    data_out = '0;
    if (bus_rd) begin
      case (reg_sel)
        PENDING: data_out = 32'(pending);
        ENABLE:  data_out = 32'(enable);
        TRIGGER: data_out = 32'(trigger);
        CLAIM:   data_out = 32'(claim_id);
        default: data_out = '0;
      endcase
    end
  end

endmodule
